wb_arbiter_2m: RTL and testbench
================================

// Module: wb_arbiter_2m
// PURPOSE
// Round-robin arbiter that shares one Wishbone classic slave (the user-project counter/register port) between two masters.
// Master 0 is the management SoC Wishbone port; master 1 is the logic-analyzer-driven bridge.
// Ownership is held for the whole cyc_i tenure, so a multi-beat transaction is never split between masters.
// A stall watchdog frees the bus if the slave never acks.
// PARAMETERS
// AW       32   address width
// DW       32   data width; sel width is DW/8
// TIMEOUT  255  wait cycles without ack before the error abort; 0 disables the watchdog
// PORTS
// clk        in   1       single clock for the whole block
// rst_n      in   1       asynchronous reset, active low
// mN_cyc_i   in   1       master N cycle (N=0,1); a high level is the bus request
// mN_stb_i   in   1       master N strobe
// mN_we_i    in   1       master N write enable
// mN_sel_i   in   DW/8    master N byte selects
// mN_adr_i   in   AW      master N address
// mN_dat_i   in   DW      master N write data
// mN_dat_o   out  DW      read data to master N; 0 when N is not granted
// mN_ack_o   out  1       ack to master N
// mN_err_o   out  1       watchdog abort to master N
// s_cyc_o    out  1       slave cycle
// s_stb_o    out  1       slave strobe
// s_we_o     out  1       slave write enable
// s_sel_o    out  DW/8    slave byte selects
// s_adr_o    out  AW      slave address
// s_dat_o    out  DW      slave write data
// s_dat_i    in   DW      slave read data
// s_ack_i    in   1       slave ack
// grant_o    out  2       one-hot current owner; 2'b00 when IDLE
// BEHAVIOUR
// - FSM states: IDLE, OWN0, OWN1. last_gnt is one flop.
// - Reset (rst_n low, async): state=IDLE, last_gnt=1, wait counter=0.
//   All outputs are 0 during reset; they are combinational from this state.
// - IDLE transitions:
//   - only m0_cyc_i high -> OWN0; only m1_cyc_i high -> OWN1.
//   - both high -> the master that is not last_gnt (m0 wins the first tie after reset).
//   - neither high -> stay in IDLE.
//   - On entering OWNx, last_gnt<=x.
// - OWNx -> IDLE when mx_cyc_i is low or on a watchdog abort.
//   - IDLE lasts at least 1 cycle: one dead cycle between owners, and no direct OWN0<->OWN1 path.
// - Grant latency: slave signals follow the request on the cycle after the cyc_i rise.
// - Slave-side mux is combinational from the granted master: s_cyc/stb/we/sel/adr/dat = mx_*.
//   - In IDLE: s_cyc_o=s_stb_o=0; sel, adr and dat are 0.
// - Response routing, for the granted master x only:
//   - mx_ack_o = s_ack_i & s_stb_o; mx_dat_o = s_dat_i.
//   - The other master sees ack=0, err=0, dat=0.
// - An s_ack_i arriving in IDLE (late ack after an abort or a cyc drop) is discarded and reaches no master.
// - Watchdog counter:
//   - width $clog2(TIMEOUT+1).
//   - increments on every cycle with s_stb_o & ~s_ack_i.
//   - clears on s_ack_i, on ~s_stb_o, and on leaving OWNx.
//   - saturates; it never wraps.
// - Abort: when TIMEOUT!=0, s_stb_o, ~s_ack_i and counter==TIMEOUT-1:
//   - mx_err_o=1 for that cycle; state -> IDLE next cycle.
//   - Net effect: err is asserted in the TIMEOUT-th unacked stb cycle.
// - Ack and err are never high together; if s_ack_i arrives in the abort cycle, ack wins and err stays 0.
// - Master x must drop cyc_i after err.
//   - If it keeps cyc_i high, it is re-arbitrated like any other request; round robin still favours the other master.
// - A mid-cycle cyc_i drop aborts silently: no err, and the slave sees s_cyc_o fall the same cycle.
// - TIMEOUT=0: no counter logic is implemented and m*_err_o are tied 0.
// - Reset asserted mid-transaction: all outputs drop to 0 immediately, independent of clk.
// TESTING
// - Single master: m0 write adr=0x0, dat=0xA5A5_0001, sel=4'hF; slave acks after 2 cycles.
//   -> s_* mirror m0 one cycle after cyc rise; m0_ack_o pulses once; grant_o=01; m1 sees no ack.
// - Tie: m0 and m1 raise cyc on the same edge, each for one read.
//   -> m0 is served first; IDLE lasts 1 cycle; then m1 (grant 01,00,10).
//   -> Next tie goes to m0, since last_gnt=1.
// - Fairness: m0 and m1 hold continuous back-to-back requests for 8 tenures.
//   -> Grants alternate 01,10,01,...; no master is starved.
// - Watchdog: TIMEOUT=4; m1 read; slave never acks.
//   -> m1_err_o high in the 4th stb cycle; s_cyc_o low next cycle.
//   -> A late s_ack_i while in IDLE is dropped.
//   - Repeat with s_ack_i in the 4th cycle: ack=1, err=0.
// - Abort and reset: m0 drops cyc while stb is pending -> IDLE next cycle, no err.
//   - rst_n low mid-OWN1, asserted between clk edges -> all outputs 0 at once.
//   - After release, the first tie goes to m0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone classic arbiter with a stall watchdog.
// Ownership spans the whole cyc tenure, with one dead IDLE cycle between owners.
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,

    output logic [1:0]      grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    logic   last_gnt;

    logic own0;
    logic own1;
    logic owned;
    logic own_cyc;
    logic abort;
    logic leave;

    assign own0    = (state == OWN0);
    assign own1    = (state == OWN1);
    assign owned   = own0 | own1;
    assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);

    // Owner releases on its own cyc drop or when the watchdog fires.
    assign leave   = owned & (~own_cyc | abort);

    // Arbitration only happens from IDLE, so owners never swap directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                        state    <= OWN0;
                        last_gnt <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state    <= OWN1;
                        last_gnt <= 1'b1;
                    end
                end
                OWN0, OWN1: begin
                    if (leave) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave side follows the granted master; everything is quiet in IDLE.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        unique case (1'b1)
            own0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            own1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Responses reach only the owner; a late ack in IDLE is dropped
    // because s_stb_o is low there.
    assign m0_ack_o = own0 & s_ack_i & s_stb_o;
    assign m1_ack_o = own1 & s_ack_i & s_stb_o;
    assign m0_err_o = own0 & abort;
    assign m1_err_o = own1 & abort;
    assign m0_dat_o = own0 ? s_dat_i : '0;
    assign m1_dat_o = own1 ? s_dat_i : '0;

    assign grant_o  = {own1, own0};

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

            logic [CW-1:0] cnt;

            // Counts consecutive unacked strobe cycles; saturates, never wraps.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (leave || s_ack_i || !s_stb_o) begin
                    cnt <= '0;
                end else if (cnt != MAX) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // Fires in the TIMEOUT-th unacked cycle; an ack in that cycle wins.
            assign abort = s_stb_o & ~s_ack_i & (cnt == LAST);
        end else begin : g_nowdog
            assign abort = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Testbench for wb_arbiter_2m: directed scenarios plus a randomized run
// checked against a tenure-level reference model.
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;

    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o;

    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o;

    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i;
    logic [1:0]    grant_o;

    int checks = 0;
    int errors = 0;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h44; m0_dat_i = 32'h1234_5678;
        m1_cyc_i = 1; m1_stb_i = 1;
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant: got %b want 00", grant_o);
        end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_slave: got %b %b %b %h %h %h want all 0",
                     s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o);
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_resp: got ack %b%b err %b%b dat %h %h want all 0",
                     m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o);
        end
        idle_inputs();
        rst_n = 1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_req: got %b want 00", grant_o);
        end
    endtask

    task automatic test_tie();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20;
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_latency: got grant %b cyc %b want 00 0", grant_o, s_cyc_o);
        end
        step();
        s_ack_i = 1; s_dat_i = 32'h1111_0000;
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b01 || s_adr_o !== 32'h10) begin
            errors++;
            $display("FAIL tie_first: got grant %b adr %h want 01 10", grant_o, s_adr_o);
        end
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1111_0000) begin
            errors++;
            $display("FAIL tie_m0_resp: got ack %b dat %h want 1 11110000", m0_ack_o, m0_dat_o);
        end
        checks++;
        if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL tie_m1_quiet: got ack %b dat %h want 0 0", m1_ack_o, m1_dat_o);
        end
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        @(negedge clk);
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_drop: got s_cyc %b want 0", s_cyc_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL tie_dead_cycle: got %b want 00", grant_o);
        end
        step();
        s_ack_i = 1; s_dat_i = 32'h2222_0000;
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b10 || s_adr_o !== 32'h20 || m1_ack_o !== 1'b1
            || m1_dat_o !== 32'h2222_0000 || m0_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL tie_second: got grant %b adr %h ack %b%b dat %h want 10 20 0 1 22220000",
                     grant_o, s_adr_o, m0_ack_o, m1_ack_o, m1_dat_o);
        end
        step();
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        step();
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL tie_next_rr: got %b want 01", grant_o);
        end
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_single();
        int acks = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h0; m0_dat_i = 32'hA5A5_0001;
        @(negedge clk);
        acks += int'(m0_ack_o) + int'(m1_ack_o);
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got s_cyc %b want 0", s_cyc_o);
        end
        step();
        @(negedge clk);
        acks += int'(m0_ack_o) + int'(m1_ack_o);
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}
            !== {2'b01, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL single_mirror: got g %b %b%b%b sel %h adr %h dat %h want 01 111 F 0 a5a50001",
                     grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o);
        end
        step();
        @(negedge clk);
        acks += int'(m0_ack_o) + int'(m1_ack_o);
        step();
        s_ack_i = 1;
        @(negedge clk);
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: got ack %b%b want m0=1 m1=0", m0_ack_o, m1_ack_o);
        end
        acks += int'(m0_ack_o) + int'(m1_ack_o);
        step();
        idle_inputs();
        @(negedge clk);
        acks += int'(m0_ack_o) + int'(m1_ack_o);
        step();
        @(negedge clk);
        acks += int'(m0_ack_o) + int'(m1_ack_o);
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL single_ack_count: got %0d want 1", acks);
        end
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] want;
        logic [1:0] g;
        int n;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1;
        s_ack_i = 1; s_dat_i = 32'h0F0F_0F0F;
        want = 2'b01;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            @(negedge clk);
            while (grant_o == 2'b00 && n < 6) begin
                step();
                @(negedge clk);
                n++;
            end
            g = grant_o;
            checks++;
            if (g !== want || {m1_ack_o, m0_ack_o} !== want) begin
                errors++;
                $display("FAIL fair_tenure%0d: got grant %b ack %b%b want %b",
                         t, g, m1_ack_o, m0_ack_o, want);
            end
            step();
            if (g[0]) begin
                m0_cyc_i = 0; m0_stb_i = 0;
            end else begin
                m1_cyc_i = 0; m1_stb_i = 0;
            end
            step();
            m0_cyc_i = 1; m0_stb_i = 1;
            m1_cyc_i = 1; m1_stb_i = 1;
            want = {want[0], want[1]};
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_watchdog();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h80;
        step();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            checks++;
            if (m1_err_o !== (k == TO) || m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
                errors++;
                $display("FAIL wdog_cycle%0d: got err %b%b ack %b want m1_err=%0d",
                         k, m0_err_o, m1_err_o, m1_ack_o, (k == TO));
            end
            step();
        end
        m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i = 1; s_dat_i = 32'h5555_AAAA;
        @(negedge clk);
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
            errors++;
            $display("FAIL wdog_release: got s_cyc %b grant %b want 0 00", s_cyc_o, grant_o);
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o} !== '0) begin
            errors++;
            $display("FAIL wdog_late_ack: got ack %b%b dat %h %h want 0",
                     m0_ack_o, m1_ack_o, m0_dat_o, m1_dat_o);
        end
        step();
        s_ack_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) s_ack_i = 1;
            @(negedge clk);
            if (k == TO) begin
                checks++;
                if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wdog_ack_wins: got ack %b err %b want 1 0", m1_ack_o, m1_err_o);
                end
            end
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_abort_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b01 || s_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_own: got grant %b stb %b want 01 1", grant_o, s_stb_o);
        end
        step();
        m0_cyc_i = 0;
        @(negedge clk);
        checks++;
        if (s_cyc_o !== 1'b0 || m0_err_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: got s_cyc %b err %b want 0 0", s_cyc_o, m0_err_o);
        end
        step();
        m0_stb_i = 0;
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00 || m0_err_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got grant %b err %b want 00 0", grant_o, m0_err_o);
        end
        step();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'h3;
        m1_adr_i = 32'hC0; m1_dat_i = 32'h7777_7777;
        s_dat_i = 32'hCAFE_F00D;
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b10) begin
            errors++;
            $display("FAIL rst_pre_own1: got %b want 10", grant_o);
        end
        #2;
        rst_n = 0;
        s_ack_i = 1;
        #1;
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_slave: got g %b %b%b%b %h %h %h want all 0",
                     grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o);
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_resp: got ack %b%b err %b%b dat %h %h want all 0",
                     m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1;
        step();
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL rst_first_tie: got %b want 01", grant_o);
        end
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_random();
        int owner;
        int prefer;
        int stall;
        int w;
        logic [1:0] cyc, stb;
        logic ostb, err_now;
        logic [1:0] eg;
        logic [70:0] es, as;
        logic [67:0] er, ar;
        do_reset();
        owner = -1;
        prefer = 0;
        stall = 0;
        for (int c = 0; c < 600; c++) begin
            m0_cyc_i = m0_cyc_i ? ($urandom_range(99) < 85) : ($urandom_range(99) < 25);
            m1_cyc_i = m1_cyc_i ? ($urandom_range(99) < 85) : ($urandom_range(99) < 25);
            m0_stb_i = m0_cyc_i & ($urandom_range(3) != 0);
            m1_stb_i = m1_cyc_i & ($urandom_range(3) != 0);
            m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            s_ack_i = ($urandom_range(2) == 0);
            s_dat_i = $urandom;
            @(negedge clk);
            cyc = {m1_cyc_i, m0_cyc_i};
            stb = {m1_stb_i, m0_stb_i};
            eg = 2'b00;
            es = '0;
            ostb = 1'b0;
            if (owner == 0) begin
                eg = 2'b01;
                es = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
            end else if (owner == 1) begin
                eg = 2'b10;
                es = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
            end
            if (owner >= 0) ostb = stb[owner];
            err_now = ostb && !s_ack_i && (stall == TO - 1);
            er = {(owner == 0) && s_ack_i && ostb, (owner == 1) && s_ack_i && ostb,
                  (owner == 0) && err_now, (owner == 1) && err_now,
                  (owner == 0) ? s_dat_i : 32'h0, (owner == 1) ? s_dat_i : 32'h0};
            as = {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o};
            ar = {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
            checks++;
            if (grant_o !== eg) begin
                errors++;
                $display("FAIL rand_grant c%0d: got %b want %b", c, grant_o, eg);
            end
            checks++;
            if (as !== es) begin
                errors++;
                $display("FAIL rand_slave c%0d: got %h want %h", c, as, es);
            end
            checks++;
            if (ar !== er) begin
                errors++;
                $display("FAIL rand_resp c%0d: got %h want %h", c, ar, er);
            end
            if (owner >= 0) begin
                if (!cyc[owner] || err_now) begin
                    owner = -1;
                    stall = 0;
                end else if (!ostb || s_ack_i) begin
                    stall = 0;
                end else begin
                    stall++;
                end
            end else if (cyc != 2'b00) begin
                w = (cyc == 2'b11) ? prefer : (cyc[0] ? 0 : 1);
                owner = w;
                prefer = 1 - w;
                stall = 0;
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_tie();
        test_single();
        test_fairness();
        test_watchdog();
        test_abort_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
